// File: rtl/can_rec_scheduler.sv
// Round-robin scheduler for per-bus CAN receive flags: edge-captures requests into a
// pending vector and hands one bus id at a time to the readout logic. Option: CAN_REC_TIMEOUT_EN.
module can_rec_scheduler #(
  parameter int N_BUSES     = 32,
  parameter int ID_W        = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BUSES-1:0] can_rec,
  input  logic               rec_ready,
  input  logic               rec_done,
  output logic               rec_valid,
  output logic [ID_W-1:0]    rec_bus_id,
  output logic [N_BUSES-1:0] pending,
  output logic               rec_lost,
  output logic               rec_timeout
);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, BUSY} state_t;

  state_t             state, state_nxt;
  logic [N_BUSES-1:0] can_rec_q;
  logic [N_BUSES-1:0] rise;
  logic [N_BUSES-1:0] clr_mask;
  logic [N_BUSES-1:0] pending_nxt;
  logic [ID_W-1:0]    last_id;
  logic [ID_W:0]      pick;
  logic               load_grant;
  logic               accept;
  logic               timeout_hit;

  // Search starts just after the previous grant; the smallest offset wins.
  function automatic logic [ID_W:0] rr_pick(input logic [N_BUSES-1:0] req,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = N_BUSES; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % N_BUSES);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign rise = can_rec & ~can_rec_q;
  assign pick = rr_pick(pending, last_id);

  // A new edge on a bit being cleared this cycle stays pending and is not a loss.
  assign pending_nxt = (pending & ~clr_mask) | rise;

`ifdef CAN_REC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] busy_cnt;

  assign timeout_hit = (state == BUSY) && !rec_done && (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 busy_cnt <= '0;
    else if (state != BUSY)  busy_cnt <= '0;
    else                     busy_cnt <= busy_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    clr_mask   = '0;
    load_grant = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: if (|pending) state_nxt = SCAN;
      SCAN: begin
        if (pick[ID_W]) begin
          load_grant = 1'b1;
          state_nxt  = GRANT;
        end else begin
          state_nxt  = IDLE;
        end
      end
      GRANT: begin
        if (rec_ready) begin
          accept               = 1'b1;
          clr_mask[rec_bus_id] = 1'b1;
          state_nxt            = BUSY;
        end
      end
      BUSY: if (rec_done || timeout_hit) state_nxt = (|pending) ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      can_rec_q   <= '0;
      pending     <= '0;
      last_id     <= ID_W'(N_BUSES - 1);
      rec_bus_id  <= '0;
      rec_valid   <= 1'b0;
      rec_lost    <= 1'b0;
      rec_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      can_rec_q   <= can_rec;
      pending     <= pending_nxt;
      rec_lost    <= |(rise & pending & ~clr_mask);
      rec_timeout <= timeout_hit;
      if (load_grant) begin
        rec_bus_id <= pick[ID_W-1:0];
        last_id    <= pick[ID_W-1:0];
        rec_valid  <= 1'b1;
      end else if (accept) begin
        rec_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_can_rec_scheduler.sv
// Bench for can_rec_scheduler: cycle-level reference model plus directed grant-order checks.
module tb_can_rec_scheduler;

  localparam int N   = 32;
  localparam int TMO = 16;
`ifdef CAN_REC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  can_rec;
  logic          rec_ready;
  logic          rec_done;
  logic          rec_valid;
  logic [4:0]    rec_bus_id;
  logic [N-1:0]  pending;
  logic          rec_lost;
  logic          rec_timeout;

  can_rec_scheduler #(.N_BUSES(N), .ID_W(5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .can_rec(can_rec), .rec_ready(rec_ready), .rec_done(rec_done),
    .rec_valid(rec_valid), .rec_bus_id(rec_bus_id), .pending(pending),
    .rec_lost(rec_lost), .rec_timeout(rec_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set of buses, phase of the handshake, round-robin pointer.
  bit m_prev[N];
  bit m_pend[N];
  int m_phase;   // 0 idle, 1 searching, 2 offering, 3 downstream busy
  int m_last, m_gid, m_cnt;
  bit m_vld, m_lost, m_tmo;

  function automatic int pick_next(input int last);
    for (int k = 1; k <= N; k++)
      if (m_pend[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_prev[i] = 0; m_pend[i] = 0; end
    m_phase = 0; m_last = N - 1; m_gid = 0; m_cnt = 0;
    m_vld = 0; m_lost = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    bit any_old;
    bit leave;
    int clr;
    int n;
    bit np[N];
    any_old = 0;
    for (int i = 0; i < N; i++) any_old |= m_pend[i];
    clr = -1; leave = 0; m_lost = 0; m_tmo = 0;
    case (m_phase)
      0: if (any_old) m_phase = 1;
      1: begin
        n = pick_next(m_last);
        if (n < 0) m_phase = 0;
        else begin m_gid = n; m_last = n; m_vld = 1; m_phase = 2; end
      end
      2: if (rec_ready) begin clr = m_gid; m_vld = 0; m_phase = 3; m_cnt = 0; end
      default: begin
        if (rec_done) leave = 1;
        else if (TMO_EN && m_cnt == TMO - 1) begin leave = 1; m_tmo = 1; end
        else m_cnt++;
        if (leave) m_phase = any_old ? 1 : 0;
      end
    endcase
    for (int i = 0; i < N; i++) begin
      bit r;
      r = can_rec[i] && !m_prev[i];
      if (r && m_pend[i] && i != clr) m_lost = 1;
      np[i] = r || (m_pend[i] && i != clr);
      m_prev[i] = can_rec[i];
    end
    for (int i = 0; i < N; i++) m_pend[i] = np[i];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Per-cycle comparison plus bookkeeping of grants and pulses seen on the DUT.
  int glog[$];
  int lost_cnt, tmo_cnt;
  bit prev_v;

  always @(negedge clk) begin
    logic [N-1:0] mp;
    for (int i = 0; i < N; i++) mp[i] = m_pend[i];
    chk("rec_valid", 32'(rec_valid), 32'(m_vld));
    if (m_vld) chk("rec_bus_id", 32'(rec_bus_id), 32'(m_gid));
    chk("pending", pending, mp);
    chk("rec_lost", 32'(rec_lost), 32'(m_lost));
    chk("rec_timeout", 32'(rec_timeout), 32'(m_tmo));
    if (rst) prev_v = 0;
    else begin
      if (prev_v && !rec_valid) glog.push_back(int'(rec_bus_id));
      prev_v = rec_valid;
      if (rec_lost) lost_cnt++;
      if (rec_timeout) tmo_cnt++;
    end
  end

  int rmode, dmode;  // 0 manual, 1 always high, 2 random

  task automatic tick();
    @(negedge clk);
    #1;
    if (rmode == 1) rec_ready = 1'b1; else if (rmode == 2) rec_ready = 1'($urandom_range(0, 1));
    if (dmode == 1) rec_done  = 1'b1; else if (dmode == 2) rec_done  = 1'($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    glog.delete(); lost_cnt = 0; tmo_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; can_rec = '0; rec_ready = 1'b0; rec_done = 1'b0; rmode = 0; dmode = 0;
    wait_n(2);
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_count"}, 32'(glog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk({name, "_order"}, 32'(glog[i]), 32'(exp[i]));
  endtask

  initial begin
    rst = 1'b1; can_rec = '0; rec_ready = 1'b0; rec_done = 1'b0; rmode = 0; dmode = 0;
    clear_logs();
    wait_n(3);
    chk("reset_valid", 32'(rec_valid), 32'd0);
    chk("reset_pending", pending, 32'd0);
    chk("reset_bus_id", 32'(rec_bus_id), 32'd0);
    chk("reset_pulses", {30'd0, rec_lost, rec_timeout}, 32'd0);

    // Single bus: latency, handshake and return to idle.
    do_reset();
    can_rec = 32'h0000_0080;
    tick();
    chk("t1_pending_set", pending, 32'h0000_0080);
    chk("t1_valid_e0", 32'(rec_valid), 32'd0);
    tick();
    chk("t1_valid_e1", 32'(rec_valid), 32'd0);
    tick();
    chk("t1_valid_e2", 32'(rec_valid), 32'd1);
    chk("t1_bus_id", 32'(rec_bus_id), 32'd7);
    wait_n(2);
    chk("t1_held", {26'd0, rec_valid, rec_bus_id}, 32'h27);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    chk("t1_pending_clr", pending, 32'd0);
    chk("t1_valid_drop", 32'(rec_valid), 32'd0);
    wait_n(3);
    rec_done = 1'b1;
    tick();
    rec_done = 1'b0;
    wait_n(3);
    chk("t1_bus_id_kept", 32'(rec_bus_id), 32'd7);
    chk_log("t1", '{7});

    // Three simultaneous requests, immediate ready/done.
    do_reset();
    rmode = 1; dmode = 1;
    can_rec = (32'd1 << 3) | (32'd1 << 20) | (32'd1 << 31);
    wait_n(30);
    chk_log("t2", '{3, 20, 31});

    // Round-robin continuation and wrap-around.
    do_reset();
    rmode = 1; dmode = 1;
    can_rec = 32'd1 << 20;
    wait_n(10);
    can_rec = can_rec | (32'd1 << 3) | (32'd1 << 25);
    wait_n(20);
    can_rec = '0;
    wait_n(3);
    can_rec = 32'd1 << 31;
    wait_n(10);
    can_rec = (32'd1 << 31) | 32'd1 | (32'd1 << 5);
    wait_n(20);
    chk_log("t3", '{20, 25, 3, 31, 0, 5});

    // Second edge before grant is lost, one grant only.
    do_reset();
    can_rec = 32'd1 << 4;
    tick();
    can_rec = '0;
    tick();
    can_rec = 32'd1 << 4;
    wait_n(2);
    rmode = 1; dmode = 1;
    wait_n(15);
    chk("t4_lost_pulses", 32'(lost_cnt), 32'd1);
    chk_log("t4", '{4});

    // Downstream never signals done.
    do_reset();
    rmode = 1; dmode = 0;
    can_rec = (32'd1 << 9) | (32'd1 << 12);
    wait_n(25);
`ifdef CAN_REC_TIMEOUT_EN
    chk("t5_timeouts", 32'(tmo_cnt), 32'd1);
    chk_log("t5", '{9, 12});
`else
    chk("t5_timeouts", 32'(tmo_cnt), 32'd0);
    chk_log("t5", '{9});
`endif
    dmode = 1;
    wait_n(10);

    // Reset while offering a grant; held levels re-trigger after release.
    do_reset();
    can_rec = 32'h0000_0081;
    wait_n(4);
    chk("t6_offer", {26'd0, rec_valid, rec_bus_id}, 32'h20);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(rec_valid), 32'd0);
    chk("t6_async_pending", pending, 32'd0);
    wait_n(2);
    clear_logs();
    rst = 1'b0;
    rmode = 1; dmode = 1;
    wait_n(20);
    chk_log("t6", '{0, 7});

    // Random traffic against the model.
    do_reset();
    rmode = 2; dmode = 2;
    for (int c = 0; c < 4000; c++) begin
      can_rec = can_rec ^ ($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    can_rec = '0;
    rmode = 1; dmode = 1;
    wait_n(200);
    chk("final_pending", pending, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
